// File: rtl/apb_slave_mem.sv
// APB completer backed by a byte-wide memory array, with fixed wait states
// and PSLVERR on addresses beyond MEM_DEPTH.
module apb_slave_mem #(
  parameter int APB_AW      = 32,
  parameter int APB_DW      = 8,
  parameter int MEM_DEPTH   = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              PCLK,
  input  logic              PRESET,
  input  logic [APB_AW-1:0] PADDR,
  input  logic              PSEL,
  input  logic              PENABLE,
  input  logic              PWRITE,
  input  logic [APB_DW-1:0] PWDATA,
  output logic [APB_DW-1:0] PRDATA,
  output logic              PREADY,
  output logic              PSLVERR
);

  localparam int IDX_W = $clog2(MEM_DEPTH);
  localparam logic [APB_AW-1:0] DEPTH_A   = APB_AW'(MEM_DEPTH);
  localparam logic [3:0]        WAIT_INIT = 4'(WAIT_CYCLES);

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_ACCESS = 1'b1;

  function automatic logic addr_err(input logic [APB_AW-1:0] a);
    return a >= DEPTH_A;
  endfunction

  function automatic logic [IDX_W-1:0] idx_of(input logic [APB_AW-1:0] a);
    return a[IDX_W-1:0];
  endfunction

  logic [0:0]        state;
  logic [3:0]        cnt;
  logic [APB_AW-1:0] addr_q;
  logic              write_q;
  logic [APB_DW-1:0] wdata_q;
  logic [APB_DW-1:0] mem [MEM_DEPTH];

  logic              setup;
  logic              resp_now;
  logic              complete;
  logic              do_write;
  logic [APB_AW-1:0] rsp_addr;
  logic              rsp_write;
  logic              rsp_err;
  logic [APB_DW-1:0] rsp_rdata;

  // With zero wait states the response is formed on the setup edge itself,
  // so the live bus is used there instead of the not-yet-captured copy.
  always_comb begin
    setup     = (state == ST_IDLE) && PSEL && !PENABLE;
    rsp_addr  = setup ? PADDR  : addr_q;
    rsp_write = setup ? PWRITE : write_q;
    rsp_err   = addr_err(rsp_addr);
    rsp_rdata = rsp_err ? '0 : mem[idx_of(rsp_addr)];
    resp_now  = (setup && (WAIT_CYCLES == 0)) ||
                ((state == ST_ACCESS) && PSEL && !PREADY && (cnt == 4'd1));
    complete  = (state == ST_ACCESS) && PSEL && PREADY;
    do_write  = complete && write_q && !PSLVERR;
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state   <= ST_IDLE;
      cnt     <= 4'd0;
      PREADY  <= 1'b0;
      PSLVERR <= 1'b0;
      PRDATA  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (setup) begin
            cnt   <= WAIT_INIT;
            state <= ST_ACCESS;
          end
        end
        default: begin
          if (!PSEL || PREADY) begin
            state   <= ST_IDLE;
            cnt     <= 4'd0;
            PREADY  <= 1'b0;
            PSLVERR <= 1'b0;
          end else if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end
        end
      endcase
      if (resp_now) begin
        PREADY  <= 1'b1;
        PSLVERR <= rsp_err;
        if (!rsp_write) PRDATA <= rsp_rdata;
      end
    end
  end

  // Transfer attributes are frozen at setup; they carry no reset.
  always_ff @(posedge PCLK) begin
    if (setup) begin
      addr_q  <= PADDR;
      write_q <= PWRITE;
      wdata_q <= PWDATA;
    end
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      for (int i = 0; i < MEM_DEPTH; i++) mem[i] <= '0;
    end else if (do_write) begin
      mem[idx_of(addr_q)] <= wdata_q;
    end
  end

endmodule

// File: tb/tb_apb_slave_mem.sv
// Randomized bench for apb_slave_mem: two instances (2 and 0 wait states)
// compared against a per-instance array model of memory and read data.
module tb_apb_slave_mem;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] psel = 2'b00;
  logic [1:0] pen  = 2'b00;
  logic [1:0] pwr  = 2'b00;
  logic [31:0] paddr [2];
  logic [7:0]  pwd   [2];
  wire  [7:0]  prdata0, prdata1;
  wire         prdy0, prdy1, perr0, perr1;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int wc [2] = '{2, 0};
  logic [7:0] ref_mem [2][256];
  logic [7:0] last_rd [2];

  apb_slave_mem #(.APB_AW(32), .APB_DW(8), .MEM_DEPTH(256), .WAIT_CYCLES(2)) dut (
    .PCLK(clk), .PRESET(rst), .PADDR(paddr[0]), .PSEL(psel[0]), .PENABLE(pen[0]),
    .PWRITE(pwr[0]), .PWDATA(pwd[0]), .PRDATA(prdata0), .PREADY(prdy0), .PSLVERR(perr0)
  );

  apb_slave_mem #(.APB_AW(32), .APB_DW(8), .MEM_DEPTH(256), .WAIT_CYCLES(0)) dut0 (
    .PCLK(clk), .PRESET(rst), .PADDR(paddr[1]), .PSEL(psel[1]), .PENABLE(pen[1]),
    .PWRITE(pwr[1]), .PWDATA(pwd[1]), .PRDATA(prdata1), .PREADY(prdy1), .PSLVERR(perr1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic rdy_of(input int d);
    return (d == 0) ? prdy0 : prdy1;
  endfunction
  function automatic logic err_of(input int d);
    return (d == 0) ? perr0 : perr1;
  endfunction
  function automatic logic [7:0] rd_of(input int d);
    return (d == 0) ? prdata0 : prdata1;
  endfunction

  task automatic clear_model();
    for (int d = 0; d < 2; d++) begin
      last_rd[d] = 8'h00;
      for (int i = 0; i < 256; i++) ref_mem[d][i] = 8'h00;
    end
  endtask

  // One complete transfer, starting with its setup cycle at the current time.
  task automatic xfer(input int d, input logic [31:0] addr, input logic wr,
                      input logic [7:0] wd, input string nm, output int rdy_cyc);
    logic err;
    logic [7:0] exp_rd;
    int k;
    bit got;
    err = (addr >= 32'd256);
    if (wr) exp_rd = last_rd[d];
    else    exp_rd = err ? 8'h00 : ref_mem[d][addr[7:0]];
    psel[d] = 1'b1; pen[d] = 1'b0; paddr[d] = addr; pwr[d] = wr; pwd[d] = wd;
    @(posedge clk); #1;
    pen[d] = 1'b1;
    k = 0; got = 1'b0; rdy_cyc = -1;
    while (!got && k <= wc[d] + 3) begin
      checks++;
      if (rdy_of(d) !== (k == wc[d])) begin
        errors++;
        $display("FAIL %s ready access_cycle=%0d got=%b exp=%b", nm, k + 1, rdy_of(d), (k == wc[d]));
      end
      if (rdy_of(d) === 1'b1) begin
        got = 1'b1;
        rdy_cyc = cyc;
        checks++;
        if (err_of(d) !== err) begin
          errors++;
          $display("FAIL %s pslverr got=%b exp=%b", nm, err_of(d), err);
        end
        checks++;
        if (rd_of(d) !== exp_rd) begin
          errors++;
          $display("FAIL %s prdata got=%h exp=%h", nm, rd_of(d), exp_rd);
        end
      end
      // Bus churn during ACCESS must not affect the captured transfer.
      paddr[d] = $urandom; pwr[d] = 1'($urandom_range(0, 1)); pwd[d] = 8'($urandom);
      @(posedge clk); #1;
      k++;
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL %s timeout waiting for PREADY got=0 exp=1", nm);
    end else if (rdy_of(d) !== 1'b0) begin
      errors++;
      $display("FAIL %s ready_after_completion got=%b exp=0", nm, rdy_of(d));
    end
    if (wr && !err) ref_mem[d][addr[7:0]] = wd;
    if (!wr) last_rd[d] = exp_rd;
    psel[d] = 1'b0; pen[d] = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      checks++;
      if ({rdy_of(d), err_of(d), rd_of(d)} !== 10'h0) begin
        errors++;
        $display("FAIL reset_outputs dut=%0d got=%b/%b/%h exp=0/0/00", d, rdy_of(d), err_of(d), rd_of(d));
      end
    end
    rst = 1'b0;
    clear_model();
  endtask

  task automatic test_basic();
    int rc;
    xfer(0, 32'h05, 1'b0, 8'h00, "read_after_reset", rc);
    xfer(0, 32'h10, 1'b1, 8'hA5, "write_10", rc);
    xfer(0, 32'h10, 1'b0, 8'h00, "read_10", rc);
  endtask

  task automatic test_idle_enable();
    psel = 2'b11; pen = 2'b11;
    paddr[0] = 32'h10; paddr[1] = 32'h10; pwr = 2'b00;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++;
      if ({prdy1, prdy0} !== 2'b00) begin
        errors++;
        $display("FAIL idle_enable_ignored cycle=%0d got=%b exp=00", i, {prdy1, prdy0});
      end
    end
    psel = 2'b00; pen = 2'b00;
  endtask

  task automatic test_back_to_back(input int d);
    int rc [4];
    int tmp;
    for (int i = 0; i < 4; i++) xfer(d, 32'h20 + i, 1'b1, 8'(8'h11 * (i + 1)), "preload", tmp);
    for (int i = 0; i < 4; i++) xfer(d, 32'h20 + i, 1'b0, 8'h00, "b2b_read", rc[i]);
    for (int i = 1; i < 4; i++) begin
      checks++;
      if (rc[i] - rc[i-1] != 2 + wc[d]) begin
        errors++;
        $display("FAIL b2b_spacing dut=%0d got=%0d exp=%0d", d, rc[i] - rc[i-1], 2 + wc[d]);
      end
    end
  endtask

  task automatic test_out_of_range(input int d);
    int rc;
    xfer(d, 32'h00, 1'b1, 8'h3C, "oor_pre", rc);
    xfer(d, 32'h100, 1'b1, 8'h77, "oor_write", rc);
    xfer(d, 32'h00, 1'b0, 8'h00, "oor_alias_read", rc);
    xfer(d, 32'h100, 1'b0, 8'h00, "oor_read", rc);
    xfer(d, 32'hFFFF_FF00, 1'b1, 8'h99, "oor_write_hi", rc);
    xfer(d, 32'h00, 1'b0, 8'h00, "oor_alias_read2", rc);
    xfer(d, 32'h0000_01FF, 1'b0, 8'h00, "oor_read_1ff", rc);
    xfer(d, 32'h0000_00FF, 1'b0, 8'h00, "read_top", rc);
  endtask

  task automatic test_abort();
    int rc;
    xfer(0, 32'h30, 1'b1, 8'h5A, "abort_pre", rc);
    psel[0] = 1'b1; pen[0] = 1'b0; paddr[0] = 32'h30; pwr[0] = 1'b1; pwd[0] = 8'hC3;
    @(posedge clk); #1;
    psel[0] = 1'b0; pen[0] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (prdy0 !== 1'b0) begin
        errors++;
        $display("FAIL abort_no_ready cycle=%0d got=%b exp=0", i, prdy0);
      end
      @(posedge clk); #1;
    end
    xfer(0, 32'h30, 1'b0, 8'h00, "abort_readback", rc);
  endtask

  task automatic test_random();
    int rc, d;
    logic [31:0] a;
    logic wr;
    for (int n = 0; n < 60; n++) begin
      d  = $urandom_range(0, 1);
      wr = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 9) < 8) a = 32'($urandom_range(0, 255));
      else a = $urandom | 32'h100;
      xfer(d, a, wr, 8'($urandom), "random", rc);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #0;
    end
  endtask

  task automatic test_async_reset();
    int rc;
    xfer(0, 32'h40, 1'b1, 8'h99, "ar_pre", rc);
    psel[0] = 1'b1; pen[0] = 1'b0; paddr[0] = 32'h40; pwr[0] = 1'b0;
    @(posedge clk); #1;
    pen[0] = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    checks++;
    if ({prdy0, prdata0} !== {1'b1, 8'h99}) begin
      errors++;
      $display("FAIL ar_ready_before_reset got=%b/%h exp=1/99", prdy0, prdata0);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({prdy0, perr0, prdata0} !== 10'h0) begin
      errors++;
      $display("FAIL ar_outputs_cleared got=%b/%b/%h exp=0/0/00", prdy0, perr0, prdata0);
    end
    psel[0] = 1'b0; pen[0] = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    psel[0] = 1'b1; pen[0] = 1'b0; paddr[0] = 32'h41; pwr[0] = 1'b1; pwd[0] = 8'h12;
    @(posedge clk); #1;
    pen[0] = 1'b1;
    #2 rst = 1'b1;
    #1 psel[0] = 1'b0; pen[0] = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    clear_model();
    xfer(0, 32'h40, 1'b0, 8'h00, "ar_read_40", rc);
    xfer(0, 32'h41, 1'b0, 8'h00, "ar_read_41", rc);
    for (int i = 0; i < 8; i++) begin
      xfer(0, 32'($urandom_range(0, 255)), 1'b0, 8'h00, "ar_cleared0", rc);
      xfer(1, 32'($urandom_range(0, 255)), 1'b0, 8'h00, "ar_cleared1", rc);
    end
    xfer(1, 32'h21, 1'b0, 8'h00, "ar_cleared1_21", rc);
  endtask

  initial begin
    paddr[0] = '0; paddr[1] = '0; pwd[0] = '0; pwd[1] = '0;
    clear_model();
    test_reset();
    @(posedge clk); #1;
    test_basic();
    test_idle_enable();
    @(posedge clk); #1;
    test_back_to_back(0);
    test_back_to_back(1);
    test_out_of_range(0);
    test_out_of_range(1);
    test_abort();
    test_random();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish got=timeout exp=finish");
    $fatal(1);
  end

endmodule
